my_demux_16_4_way_buffered: RTL and testbench

Buffered 16-bit 1-to-4 demultiplexer: accepts a stream of words, each tagged with a 2-bit destination select, and routes every word to one of four output channels (a, b, c, d). Each channel has its own small synchronous FIFO and a valid/ready handshake, so a stalled consumer never loses data. It is the distribution-side counterpart of my_mux_16_4_way and uses the same select encoding: 00→a, 01→b, 10→c, 11→d.

---
 rtl/my_demux_16_4_way_buffered_pkg.sv | 16 +
 rtl/my_demux_16_4_way_buffered_if.sv | 34 +++
 rtl/my_demux_16_4_way_buffered_fifo.sv | 51 +++++
 rtl/my_demux_16_4_way_buffered.sv | 49 ++++
 tb/tb_my_demux_16_4_way_buffered.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/my_demux_16_4_way_buffered_pkg.sv
// Shared constants and select encoding for the 16-bit 4-way mux/demux family.
// Select encoding: 00 -> a, 01 -> b, 10 -> c, 11 -> d.
package my_demux_pkg;

   localparam int WIDTH_DEFAULT = 16;
   localparam int DEPTH_DEFAULT = 2;
   localparam int NUM_CH        = 4;

   typedef enum logic [1:0] {
      CH_A = 2'b00,
      CH_B = 2'b01,
      CH_C = 2'b10,
      CH_D = 2'b11
   } chan_t;

endpackage

// File: rtl/my_demux_16_4_way_buffered_if.sv
// Input stream plus four output channels; master drives the input and consumer readies.
// The slave side (the demux) returns in_ready and the channel data/valids.
interface my_demux_16_4_way_buffered_if
   import my_demux_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
);

   logic [WIDTH-1:0] in_data;
   logic [1:0]       in_sel;
   logic             in_valid;
   logic             in_ready;

   logic [WIDTH-1:0] a, b, c, d;
   logic             a_valid, b_valid, c_valid, d_valid;
   logic             a_ready, b_ready, c_ready, d_ready;

   modport master (
      output in_data, in_sel, in_valid,
      output a_ready, b_ready, c_ready, d_ready,
      input  in_ready,
      input  a, b, c, d,
      input  a_valid, b_valid, c_valid, d_valid
   );

   modport slave (
      input  in_data, in_sel, in_valid,
      input  a_ready, b_ready, c_ready, d_ready,
      output in_ready,
      output a, b, c, d,
      output a_valid, b_valid, c_valid, d_valid
   );

endinterface

// File: rtl/my_demux_16_4_way_buffered_fifo.sv
// Synchronous FIFO; pushed word readable one cycle after the push edge.
// Push ignored when full and pop ignored when empty; no pop-to-push bypass.
module my_fifo_sync #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0]    rd_ptr, wr_ptr;
   logic [AW:0]      count;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push, do_pop;

   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign data_out = mem[rd_ptr];

   // DEPTH is a power of two, so pointers wrap for free.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= data_in;
   end

endmodule

// File: rtl/my_demux_16_4_way_buffered.sv
// Buffered 1-to-4 demux: one-cycle latency from accept edge to channel valid.
// in_ready = selected FIFO not full; each channel pops independently on its own ready.
module my_demux_16_4_way_buffered
   import my_demux_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT,
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   my_demux_16_4_way_buffered_if.slave bus
);

   logic [NUM_CH-1:0] push, pop, full, empty, rdy;
   logic [WIDTH-1:0]  head [NUM_CH];

   assign rdy          = {bus.d_ready, bus.c_ready, bus.b_ready, bus.a_ready};
   assign bus.in_ready = !full[bus.in_sel];

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign push[i] = bus.in_valid && (bus.in_sel == 2'(i)) && !full[i];
      assign pop[i]  = rdy[i] && !empty[i];

      my_fifo_sync #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk      (clk),
         .rst_n    (rst_n),
         .push     (push[i]),
         .pop      (pop[i]),
         .data_in  (bus.in_data),
         .data_out (head[i]),
         .full     (full[i]),
         .empty    (empty[i])
      );
   end

   // Masked outputs keep stale FIFO contents off the channel buses.
   assign bus.a_valid = !empty[CH_A];
   assign bus.b_valid = !empty[CH_B];
   assign bus.c_valid = !empty[CH_C];
   assign bus.d_valid = !empty[CH_D];
   assign bus.a       = empty[CH_A] ? '0 : head[CH_A];
   assign bus.b       = empty[CH_B] ? '0 : head[CH_B];
   assign bus.c       = empty[CH_C] ? '0 : head[CH_C];
   assign bus.d       = empty[CH_D] ? '0 : head[CH_D];

endmodule

// File: tb/tb_my_demux_16_4_way_buffered.sv
// Bench for the buffered 4-way demux: directed steps plus random traffic,
// checked each cycle against per-channel word queues.
module tb_my_demux_16_4_way_buffered;
   import my_demux_pkg::*;

   localparam int W = 16;
   localparam int D = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   my_demux_16_4_way_buffered_if #(.WIDTH(W)) bus ();

   my_demux_16_4_way_buffered #(.WIDTH(W), .DEPTH(D)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int vectors = 0;
   int miscompares = 0;
   logic [W-1:0] mq [4][$];
   logic [W-1:0] dlog [$];

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] obs_dat(input int i);
      case (i)
         0: return bus.a;
         1: return bus.b;
         2: return bus.c;
         default: return bus.d;
      endcase
   endfunction

   function automatic logic obs_vld(input int i);
      case (i)
         0: return bus.a_valid;
         1: return bus.b_valid;
         2: return bus.c_valid;
         default: return bus.d_valid;
      endcase
   endfunction

   function automatic logic [3:0] cur_rdy();
      return {bus.d_ready, bus.c_ready, bus.b_ready, bus.a_ready};
   endfunction

   task automatic set_rdy(input logic [3:0] r);
      {bus.d_ready, bus.c_ready, bus.b_ready, bus.a_ready} = r;
   endtask

   task automatic drive(input logic v, input logic [1:0] s, input logic [W-1:0] x);
      bus.in_valid = v;
      bus.in_sel   = s;
      bus.in_data  = x;
   endtask

   task automatic clear_model();
      for (int i = 0; i < 4; i++) mq[i].delete();
   endtask

   task automatic check_outputs();
      logic v;
      chk("in_ready", W'(bus.in_ready), W'(mq[bus.in_sel].size() < D));
      for (int i = 0; i < 4; i++) begin
         v = (mq[i].size() > 0);
         chk($sformatf("valid_%0d", i), W'(obs_vld(i)), W'(v));
         chk($sformatf("data_%0d", i), obs_dat(i), v ? mq[i][0] : '0);
      end
   endtask

   // One clock: check at the falling edge, then apply the model's push/pop at the rising edge.
   task automatic cycle();
      logic       pu;
      logic [3:0] po;
      logic [1:0] s;
      logic [W-1:0] x;
      @(negedge clk);
      check_outputs();
      if (bus.d_valid && bus.d_ready) dlog.push_back(bus.d);
      s  = bus.in_sel;
      x  = bus.in_data;
      pu = bus.in_valid && (mq[s].size() < D);
      for (int i = 0; i < 4; i++) po[i] = (mq[i].size() > 0) && cur_rdy()[i];
      @(posedge clk);
      if (!rst_n) begin
         clear_model();
      end else begin
         for (int i = 0; i < 4; i++) if (po[i]) void'(mq[i].pop_front());
         if (pu) mq[s].push_back(x);
      end
      #1;
   endtask

   initial begin
      int n;
      int guard;
      logic acc;
      logic tog;

      clear_model();
      set_rdy(4'hF);
      drive(1'b1, 2'b00, 16'hDEAD);
      repeat (2) cycle();
      rst_n = 1'b1;

      // Idle after reset: nothing may appear.
      drive(1'b0, 2'b00, 16'h0000);
      repeat (10) cycle();

      // Routing across all four channels.
      drive(1'b1, CH_A, 16'h8000); cycle();
      drive(1'b1, CH_B, 16'h0800); cycle();
      drive(1'b1, CH_C, 16'h0080); cycle();
      drive(1'b1, CH_D, 16'h0008); cycle();
      drive(1'b0, CH_A, 16'h0000);
      repeat (3) cycle();

      // Backpressure on b until full, then release.
      set_rdy(4'b1101);
      drive(1'b1, CH_B, 16'h0001); cycle();
      drive(1'b1, CH_B, 16'h0002); cycle();
      drive(1'b1, CH_B, 16'h0003); cycle();
      drive(1'b0, CH_A, 16'h0003); cycle();
      drive(1'b1, CH_B, 16'h0003);
      set_rdy(4'hF);
      repeat (2) cycle();
      drive(1'b0, CH_A, 16'h0000);
      repeat (3) cycle();

      // Full channel c: pop and refused push in the same cycle.
      set_rdy(4'b1011);
      drive(1'b1, CH_C, 16'h00C1); cycle();
      drive(1'b1, CH_C, 16'h00C2); cycle();
      drive(1'b1, CH_C, 16'h00C3);
      set_rdy(4'hF);
      repeat (2) cycle();
      drive(1'b0, CH_A, 16'h0000);
      repeat (3) cycle();

      // Pointer wrap on d with toggling d_ready.
      dlog.delete();
      n = 0;
      guard = 0;
      tog = 1'b1;
      while (n < 8 && guard < 100) begin
         drive(1'b1, CH_D, 16'h0010 + 16'(n));
         bus.d_ready = tog;
         acc = (mq[3].size() < D);
         cycle();
         if (acc) n++;
         tog = ~tog;
         guard++;
      end
      chk("wrap_words_sent", 16'(n), 16'd8);
      drive(1'b0, CH_A, 16'h0000);
      bus.d_ready = 1'b1;
      repeat (4) cycle();
      chk("wrap_count", 16'(dlog.size()), 16'd8);
      for (int k = 0; k < 8 && k < dlog.size(); k++)
         chk($sformatf("wrap_word_%0d", k), dlog[k], 16'h0010 + 16'(k));

      // Reset mid-operation with a and c holding two words each.
      set_rdy(4'h0);
      drive(1'b1, CH_A, 16'hA001); cycle();
      drive(1'b1, CH_A, 16'hA002); cycle();
      drive(1'b1, CH_C, 16'hC001); cycle();
      drive(1'b1, CH_C, 16'hC002); cycle();
      drive(1'b0, CH_A, 16'h0000); cycle();
      rst_n = 1'b0;
      clear_model();
      #1;
      check_outputs();
      #1;
      rst_n = 1'b1;
      set_rdy(4'hF);
      drive(1'b1, CH_A, 16'hBEEF); cycle();
      drive(1'b0, CH_A, 16'h0000);
      repeat (3) cycle();

      // Random traffic.
      for (int r = 0; r < 400; r++) begin
         drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom));
         set_rdy(4'($urandom_range(0, 15)));
         cycle();
      end
      drive(1'b0, CH_A, 16'h0000);
      set_rdy(4'hF);
      repeat (4) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
